// File: rtl/pwm_cap_pkg.sv
// Shared state encoding and default sizing for the PWM capture block.
package pwm_cap_pkg;

  typedef enum logic [1:0] {ARM, HIGH, LOW} pwm_cap_state_t;

  localparam int PWM_CAP_CNT_W      = 16;
  localparam int PWM_CAP_MAX_PERIOD = 1024;
  localparam int PWM_CAP_FILT_LEN   = 3;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronises the async PWM pin, optionally glitch-filters it (PWM_CAPTURE_FILTER_EN),
// and produces level plus single-cycle rise/fall pulses.
module pwm_edge_sync
  import pwm_cap_pkg::*;
#(
  parameter int FILT_LEN = PWM_CAP_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // Edges stay suppressed until every stage of the level path holds a real pin sample,
  // so a pin already high at reset release is not mistaken for a rise.
  localparam int WARM   = 3 + FILT_LEN;
  localparam int WARM_W = $clog2(WARM + 1);

  logic              r_meta;
  logic              r_sync;
  logic              r_level_d;
  logic [WARM_W-1:0] r_warm;
  logic              w_level;
  logic              w_edge_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta    <= 1'b0;
      r_sync    <= 1'b0;
      r_level_d <= 1'b0;
      r_warm    <= '0;
    end else begin
      r_meta    <= pwm_in;
      r_sync    <= r_meta;
      r_level_d <= w_level;
      if (r_warm != WARM_W'(WARM)) r_warm <= r_warm + 1'b1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FILT_CW = $clog2(FILT_LEN + 1);

  logic               r_filt;
  logic [FILT_CW-1:0] r_fcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync != r_filt) begin
      if (r_fcnt == FILT_CW'(FILT_LEN - 1)) begin
        r_filt <= r_sync;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  assign w_edge_en = (r_warm == WARM_W'(WARM));
  assign level     = w_level;
  assign rise      = w_edge_en &  w_level & ~r_level_d;
  assign fall      = w_edge_en & ~w_level &  r_level_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an async PWM input, one strobe per period, with a stuck-input
// timeout. Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W      = PWM_CAP_CNT_W,
  parameter int MAX_PERIOD = PWM_CAP_MAX_PERIOD,
  parameter int FILT_LEN   = PWM_CAP_FILT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             valid_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] period_o,
  output logic             timeout_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_cap_state_t   r_state;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_hold;
  logic             r_valid;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_period;
  logic             r_timeout;

  pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (w_level),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ARM;
      r_per       <= '0;
      r_hi        <= '0;
      r_hold      <= '0;
      r_valid     <= 1'b0;
      r_high_time <= '0;
      r_period    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // A rise always wins over the timeout, even in the cycle the period counter tops out.
      if (w_rise) begin
        if (r_state == LOW) begin
          r_valid     <= 1'b1;
          r_high_time <= r_hold;
          r_period    <= r_per;
          r_timeout   <= 1'b0;
        end
        r_state <= HIGH;
        r_per   <= ONE;
        r_hi    <= ONE;
      end else if (r_per == MAXP) begin
        r_valid     <= 1'b1;
        r_timeout   <= 1'b1;
        r_period    <= MAXP;
        r_high_time <= w_level ? MAXP : '0;
        r_per       <= ONE;
        r_state     <= ARM;
      end else begin
        r_per <= r_per + ONE;
        if (r_state == HIGH) begin
          if (r_hi != MAXP) r_hi <= r_hi + ONE;
          if (w_fall) begin
            r_state <= LOW;
            r_hold  <= r_hi;
          end
        end
      end
    end
  end

  assign valid_o     = r_valid;
  assign high_time_o = r_high_time;
  assign period_o    = r_period;
  assign timeout_o   = r_timeout;
  assign level_o     = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  localparam int CW   = 16;
  localparam int MAXP = 1024;
  localparam int PER  = 256;

  typedef struct packed {
    logic [CW-1:0] hi;
    logic [CW-1:0] per;
    logic          to;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pwm_in = 1'b0;
  logic          valid_o;
  logic [CW-1:0] high_time_o;
  logic [CW-1:0] period_o;
  logic          timeout_o;
  logic          level_o;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   armed = 1'b0;
  int   last_duty = 0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(CW), .MAX_PERIOD(MAXP), .FILT_LEN(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .valid_o     (valid_o),
    .high_time_o (high_time_o),
    .period_o    (period_o),
    .timeout_o   (timeout_o),
    .level_o     (level_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int hi, input int per, input bit to);
    exp_t e;
    e.hi  = CW'(hi);
    e.per = CW'(per);
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One pwm_generator period: rise at cycle 0, high for duty cycles; optional reset pulse
  // and optional 2-cycle glitch in the low phase.
  task automatic run_period(input int duty, input int rst_at, input int glitch_at);
    if (armed) push_exp(last_duty, PER, 1'b0);
    armed     = 1'b1;
    last_duty = duty;
    for (int c = 0; c < PER; c++) begin
      pwm_in = (c < duty) || (glitch_at > 0 && c >= glitch_at && c < glitch_at + 2);
      if (c == rst_at) rst = 1'b0;
      tick();
      if (c == rst_at) begin
        check("rst_mid_high", {30'd0, valid_o, high_time_o, period_o, timeout_o, level_o}, 64'd0);
        rst   = 1'b1;
        armed = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && valid_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: got hi=%0d per=%0d to=%0d, none expected",
                 high_time_o, period_o, timeout_o);
      end else begin
        e = sb.pop_front();
        if ({high_time_o, period_o, timeout_o} !== e) begin
          bad++;
          $display("FAIL strobe: got hi=%0d per=%0d to=%0d expected hi=%0d per=%0d to=%0d",
                   high_time_o, period_o, timeout_o, e.hi, e.per, e.to);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d strobes pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    check("reset_state", {30'd0, valid_o, high_time_o, period_o, timeout_o, level_o}, 64'd0);
    rst = 1'b1;
    repeat (10) tick();

    // 50% duty: first rise arms, then 128/256 per period
    repeat (4) run_period(128, -1, 0);
    // 4 then 192: the first full 192 period reports 192/256
    repeat (3) run_period(4, -1, 0);
    repeat (2) run_period(192, -1, 0);

    // stuck low: three timeouts with high_time 0
    repeat (3) push_exp(0, MAXP, 1'b1);
    armed  = 1'b0;
    pwm_in = 1'b0;
    repeat (3300) tick();

    // stuck high: that rise only arms, then two timeouts with high_time MAX
    repeat (2) push_exp(MAXP, MAXP, 1'b1);
    pwm_in = 1'b1;
    repeat (1200) tick();
    check("level_stuck_high", {63'd0, level_o}, 64'd1);
    repeat (1348) tick();
    pwm_in = 1'b0;
    repeat (100) tick();
    armed = 1'b0;
    check("hold_after_timeout", {30'd0, high_time_o, period_o, timeout_o, 1'b0},
          {30'd0, 16'd1024, 16'd1024, 1'b1, 1'b0});

    // resume at duty 64: arm period, then 64/256
    repeat (3) run_period(64, -1, 0);

    // reset in the high phase, then two rises before the next strobe
    run_period(128, 60, 0);
    repeat (3) run_period(128, -1, 0);

`ifdef PWM_CAPTURE_FILTER_EN
    repeat (3) run_period(128, -1, 180);
    run_period(128, -1, 0);
`endif

    repeat (20) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
